// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED decode engine: FSM states, decode flags
// and where the data bits sit inside a 16-bit extended Hamming codeword.
package secded_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    DECODE,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SGL = 2'b01;
  localparam logic [1:0] FLAG_DBL = 2'b10;

  localparam int CW_BITS   = 16;
  localparam int DATA_BITS = 11;

  // d1 sits alone at position 3, d2..d4 at 5..7, d5..d11 at 9..15
  localparam int D1_POS = 3;
  localparam int D2_POS = 5;
  localparam int D5_POS = 9;

  function automatic logic [DATA_BITS-1:0] extract_data(input logic [CW_BITS-1:0] cw);
    return {cw[D5_POS +: 7], cw[D2_POS +: 3], cw[D1_POS]};
  endfunction

endpackage

// File: rtl/secded_correct.sv
// Combinational SECDED check/correct: syndrome plus overall parity select
// between pass-through, single-bit correction and double-error flagging.
module secded_correct
  import secded_pkg::*;
(
  input  logic [CW_BITS-1:0]   cw,
  output logic [DATA_BITS-1:0] data,
  output logic [1:0]           flag
);

  logic [3:0]         term [CW_BITS];
  logic [3:0]         syn;
  logic               par;
  logic [CW_BITS-1:0] fixed_cw;

  genvar gi;
  generate
    for (gi = 0; gi < CW_BITS; gi++) begin : g_term
      assign term[gi] = cw[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  always_comb begin
    syn = 4'd0;
    for (int k = 0; k < CW_BITS; k++) begin
      syn = syn ^ term[k];
    end
    par      = ^cw;
    fixed_cw = cw;
    flag     = FLAG_OK;
    // Odd overall parity means one flipped bit; syndrome 0 points at p0 itself
    if (par) begin
      fixed_cw[syn] = ~cw[syn];
      flag          = FLAG_SGL;
    end else if (syn != 4'd0) begin
      flag = FLAG_DBL;
    end
    data = extract_data(fixed_cw);
  end

endmodule

// File: rtl/secded_decode_engine.sv
// Walks NUM_WORDS codewords from SRC_BASE, decodes each and writes data plus
// flag to DST_BASE, five cycles per word, counting corrected/detected errors.
module secded_decode_engine
  import secded_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  output logic       ack,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [3:0] single_cnt,
  output logic [3:0] double_cnt
);

  localparam logic [6:0] LAST_IDX = 7'(NUM_WORDS - 1);
  localparam logic [7:0] SRC_ADDR = 8'(SRC_BASE);
  localparam logic [7:0] DST_ADDR = 8'(DST_BASE);

  state_t               state_reg, state_next;
  logic [6:0]           idx_reg;
  logic [7:0]           lo_reg, hi_reg;
  logic [DATA_BITS-1:0] data_reg, fix_data;
  logic [1:0]           flag_reg, fix_flag;
  logic                 ack_reg;
  logic [3:0]           single_reg, double_reg;
  logic [7:0]           word_off;

  assign word_off   = {idx_reg, 1'b0};
  assign ack        = ack_reg;
  assign single_cnt = single_reg;
  assign double_cnt = double_reg;

  secded_correct u_correct (
    .cw   ({hi_reg, lo_reg}),
    .data (fix_data),
    .flag (fix_flag)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state_reg)
      IDLE:   if (req) state_next = RD_LO;
      RD_LO: begin
        mem_addr   = SRC_ADDR + word_off;
        state_next = RD_HI;
      end
      RD_HI: begin
        mem_addr   = SRC_ADDR + word_off + 8'd1;
        state_next = DECODE;
      end
      DECODE: state_next = WR_LO;
      WR_LO: begin
        mem_addr    = DST_ADDR + word_off;
        mem_wr_en   = 1'b1;
        mem_wr_data = data_reg[7:0];
        state_next  = WR_HI;
      end
      WR_HI: begin
        mem_addr    = DST_ADDR + word_off + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = {flag_reg, 3'b000, data_reg[10:8]};
        state_next  = (idx_reg < LAST_IDX) ? RD_LO : DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_reg    <= '0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      data_reg   <= '0;
      flag_reg   <= FLAG_OK;
      ack_reg    <= 1'b0;
      single_reg <= '0;
      double_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            ack_reg    <= 1'b0;
            idx_reg    <= '0;
            single_reg <= '0;
            double_reg <= '0;
          end
        end
        RD_LO: lo_reg <= mem_rd_data;
        RD_HI: hi_reg <= mem_rd_data;
        DECODE: begin
          data_reg <= fix_data;
          flag_reg <= fix_flag;
          if (fix_flag == FLAG_SGL && single_reg != 4'hF) single_reg <= single_reg + 4'd1;
          if (fix_flag == FLAG_DBL && double_reg != 4'hF) double_reg <= double_reg + 4'd1;
        end
        WR_HI: if (idx_reg < LAST_IDX) idx_reg <= idx_reg + 7'd1;
        DONE:  ack_reg <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_decode_engine.sv
// Bench for secded_decode_engine: encodes random data, injects known flips
// and predicts each output word from the number of flips injected.
module tb_secded_decode_engine;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       req     = 1'b0;
  logic       ack, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0] single_cnt, double_cnt;

  logic [7:0] mem [256];
  logic [7:0] exp_lo [NW];
  logic [7:0] exp_hi [NW];
  int         exp_single, exp_double;
  int         checks   = 0;
  int         failures = 0;
  int         dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  secded_decode_engine #(
    .NUM_WORDS (NW),
    .SRC_BASE  (SRC),
    .DST_BASE  (DST)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .ack         (ack),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .single_cnt  (single_cnt),
    .double_cnt  (double_cnt)
  );

  always #5 clock = ~clock;

  assign mem_rd_data = mem[mem_addr];
  always @(posedge clock) if (mem_wr_en) mem[mem_addr] = mem_wr_data;

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    logic        b;
    cw = '0;
    for (int j = 0; j < 11; j++) cw[dpos[j]] = d[j];
    for (int p = 1; p < 16; p = p * 2) begin
      b = 1'b0;
      for (int k = 3; k < 16; k++)
        if ((k & p) != 0 && (k & (k - 1)) != 0) b = b ^ cw[k];
      cw[p] = b;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    for (int j = 0; j < 11; j++) d[j] = cw[dpos[j]];
    return d;
  endfunction

  // mode 0: directed words first then clean; 1: random 0/1/2 flips; 2: one flip each
  task automatic prepare(input int mode);
    logic [10:0] d;
    logic [15:0] cw, e;
    int nf, a, b;
    exp_single = 0;
    exp_double = 0;
    for (int j = 0; j < 2 * NW; j++) mem[DST + j] = 8'hEE;
    for (int i = 0; i < NW; i++) begin
      d  = 11'($urandom);
      a  = $urandom_range(0, 15);
      b  = (a + $urandom_range(1, 15)) % 16;
      nf = (mode == 1) ? $urandom_range(0, 2) : (mode == 2) ? 1 : 0;
      if (mode == 0) begin
        case (i)
          0: begin d = 11'd1; nf = 0; end
          1: begin d = 11'd1; nf = 1; a = 3; end
          2: begin d = 11'd1; nf = 2; a = 3; b = 15; end
          3: begin d = 11'd0; nf = 1; a = 0; end
          default: ;
        endcase
      end
      cw = encode(d);
      if (nf >= 1) cw[a] = ~cw[a];
      if (nf == 2) cw[b] = ~cw[b];
      mem[SRC + 2 * i]     = cw[7:0];
      mem[SRC + 2 * i + 1] = cw[15:8];
      if (nf == 0) e = {2'b00, 3'b000, d};
      else if (nf == 1) begin
        e = {2'b01, 3'b000, d};
        if (exp_single < 15) exp_single++;
      end else begin
        e = {2'b10, 3'b000, extract(cw)};
        if (exp_double < 15) exp_double++;
      end
      exp_hi[i] = e[15:8];
      exp_lo[i] = e[7:0];
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack);
    else checks += 0;
    if (ack !== 1'b0) failures++;
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
    checks++; if (mem_addr !== 8'd0) begin failures++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    checks++; if (single_cnt !== 4'd0) begin failures++; $display("FAIL reset_single: got %0d want 0", single_cnt); end
    checks++; if (double_cnt !== 4'd0) begin failures++; $display("FAIL reset_double: got %0d want 0", double_cnt); end
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL idle_ack: got %b want 0", ack); end
  endtask

  task automatic test_decode(input int mode);
    logic [15:0] dir_exp [4] = '{16'h0001, 16'h4001, 16'h8400, 16'h4000};
    int cyc;
    prepare(mode);
    @(negedge clock); req = 1'b1;
    @(negedge clock); req = 1'b0;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL m%0d ack_clear: got %b want 0", mode, ack); end
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock); #1;
      if (ack === 1'b1) begin cyc = c; break; end
    end
    checks++; if (cyc != 5 * NW + 1) begin failures++; $display("FAIL m%0d latency: got %0d want %0d", mode, cyc, 5 * NW + 1); end
    checks++; if (single_cnt !== 4'(exp_single)) begin failures++; $display("FAIL m%0d single_cnt: got %0d want %0d", mode, single_cnt, exp_single); end
    checks++; if (double_cnt !== 4'(exp_double)) begin failures++; $display("FAIL m%0d double_cnt: got %0d want %0d", mode, double_cnt, exp_double); end
    checks++; if (mem_addr !== 8'd0 || mem_wr_en !== 1'b0) begin failures++; $display("FAIL m%0d done_idle: got addr %h en %b want 00 0", mode, mem_addr, mem_wr_en); end
    for (int i = 0; i < NW; i++) begin
      checks++; if (mem[DST + 2 * i] !== exp_lo[i]) begin failures++; $display("FAIL m%0d word%0d_lo: got %h want %h", mode, i, mem[DST + 2 * i], exp_lo[i]); end
      checks++; if (mem[DST + 2 * i + 1] !== exp_hi[i]) begin failures++; $display("FAIL m%0d word%0d_hi: got %h want %h", mode, i, mem[DST + 2 * i + 1], exp_hi[i]); end
    end
    if (mode == 0) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({mem[DST + 2 * i + 1], mem[DST + 2 * i]} !== dir_exp[i]) begin
          failures++;
          $display("FAIL directed%0d: got %h%h want %h", i, mem[DST + 2 * i + 1], mem[DST + 2 * i], dir_exp[i]);
        end
      end
    end
  endtask

  task automatic test_ack_hold();
    repeat (6) @(negedge clock);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL ack_hold: got %b want 1", ack); end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] snap [2 * NW];
    int diffs, cyc;
    prepare(1);
    @(negedge clock); req = 1'b1;
    @(negedge clock); req = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    checks++; if (mem_wr_en !== 1'b1) begin failures++; $display("FAIL midrun_writing: got %b want 1", mem_wr_en); end
    #1; reset_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL midrun_ack: got %b want 0", ack); end
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL midrun_wr_en: got %b want 0", mem_wr_en); end
    checks++; if (mem_addr !== 8'd0) begin failures++; $display("FAIL midrun_addr: got %h want 00", mem_addr); end
    checks++; if (single_cnt !== 4'd0 || double_cnt !== 4'd0) begin failures++; $display("FAIL midrun_cnt: got %0d/%0d want 0/0", single_cnt, double_cnt); end
    for (int j = 0; j < 2 * NW; j++) snap[j] = mem[DST + j];
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    diffs = 0;
    for (int j = 0; j < 2 * NW; j++) if (mem[DST + j] !== snap[j]) diffs++;
    checks++; if (diffs != 0) begin failures++; $display("FAIL midrun_no_writes: got %0d changed bytes want 0", diffs); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL midrun_ack_after: got %b want 0", ack); end

    prepare(1);
    @(negedge clock); req = 1'b1;
    @(negedge clock); req = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock); #1;
      if (c == 30) req = 1'b1;
      if (c == 31) req = 1'b0;
      if (ack === 1'b1) begin cyc = c; break; end
    end
    req = 1'b0;
    checks++; if (cyc != 5 * NW + 1) begin failures++; $display("FAIL restart_latency: got %0d want %0d", cyc, 5 * NW + 1); end
    checks++; if (single_cnt !== 4'(exp_single) || double_cnt !== 4'(exp_double)) begin
      failures++; $display("FAIL restart_cnt: got %0d/%0d want %0d/%0d", single_cnt, double_cnt, exp_single, exp_double);
    end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if ({mem[DST + 2 * i + 1], mem[DST + 2 * i]} !== {exp_hi[i], exp_lo[i]}) begin
        failures++;
        $display("FAIL restart_word%0d: got %h%h want %h%h", i, mem[DST + 2 * i + 1], mem[DST + 2 * i], exp_hi[i], exp_lo[i]);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
    test_reset();
    test_decode(0);
    test_ack_hold();
    test_decode(1);
    test_decode(2);
    test_decode(1);
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
